// File: rtl/img_pkg.sv
// Shared constants, address type and FSM encoding for the image stream source.
package img_pkg;

  localparam int IMG_W   = 256;             // pixels per line
  localparam int IMG_H   = 128;             // lines per frame
  localparam int ADDR_W  = 15;              // pixel address width
  localparam int NPIX    = IMG_W * IMG_H;   // pixels per frame
  localparam int LAG     = 258;             // filter input-to-window-centre delay
  localparam int BYTE_AW = ADDR_W - 3;      // frame store byte address width

  typedef logic [ADDR_W-1:0] pix_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } tx_state_t;

endpackage

// File: rtl/img_stream_tx_frame_ram.sv
// Byte-wide frame store: one write port, one synchronous read port, one clock.
module frame_ram
  import img_pkg::*;
(
  input  logic               clock,
  input  logic               we,
  input  logic [BYTE_AW-1:0] wr_addr,
  input  logic [7:0]         wr_data,
  input  logic [BYTE_AW-1:0] rd_addr,
  output logic [7:0]         rd_data
);

  logic [7:0] mem [2**BYTE_AW];

  // Write port plus registered read; old data is returned on a same-address collision.
  // NOTE: the array has no reset branch so it maps onto block RAM and the image survives a reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/img_stream_tx.sv
// Frame source for the binary morphology filter: streams a stored 256x128
// 1-bit image one pixel per clock with a centre-aligned cache address, then
// flushes LAG zero pixels and pulses done.
module img_stream_tx
  import img_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [BYTE_AW-1:0] wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               start,
  output logic               busy,
  output logic               income,
  output logic               pix_valid,
  output logic               frame_start,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               done
);

  localparam pix_addr_t LAST_PIX  = pix_addr_t'(NPIX - 1);
  // FLUSH runs two extra cycles so the read/select pipeline drains before DONE.
  localparam pix_addr_t FLUSH_END = pix_addr_t'(LAG + 1);
  localparam pix_addr_t LAG_A     = pix_addr_t'(LAG);

  tx_state_t state, next_state;
  pix_addr_t cnt;
  logic      busy_d, done_d;
  logic [7:0] rd_data;

  // Stage between the frame store read and the output registers.
  logic      s1_valid, s1_pix, s1_first;
  logic [2:0] s1_bit;
  pix_addr_t s1_cnt;

  // Host writes are only taken while idle so the image is stable for a whole frame.
  frame_ram u_ram (
    .clock   (clock),
    .we      (wr_en & ~busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (cnt[ADDR_W-1:3]),
    .rd_data (rd_data)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: start is only looked at in IDLE.
  // NOTE: next_state is defaulted first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (start)             next_state = STREAM;
      STREAM: if (cnt == LAST_PIX)   next_state = FLUSH;
      FLUSH:  if (cnt == FLUSH_END)  next_state = DONE;
      DONE:                          next_state = IDLE;
    endcase
  end

  // Output decode from the next state, registered below so busy/done align with the state.
  always_comb begin
    busy_d = (next_state == STREAM) || (next_state == FLUSH);
    done_d = (next_state == DONE);
  end

  // Registered FSM outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Pixel counter: pixel index in STREAM, flush index in FLUSH; wraps into FLUSH at end of frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == STREAM || state == FLUSH) begin
      cnt <= cnt + pix_addr_t'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Track the pixel whose byte is being read so it meets rd_data one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pix   <= 1'b0;
      s1_first <= 1'b0;
      s1_bit   <= '0;
      s1_cnt   <= '0;
    end else begin
      s1_valid <= (state == STREAM) || (state == FLUSH && cnt < LAG_A);
      s1_pix   <= (state == STREAM);
      s1_first <= (state == STREAM) && (cnt == '0);
      s1_bit   <= cnt[2:0];
      s1_cnt   <= cnt;
    end
  end

  // Output registers: bit select (MSB first), zero during flush, address offset by LAG.
  // Flush indices restart at 0, which is congruent to NPIX+j, so one subtract covers both phases.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      income      <= 1'b0;
      out_addr    <= '0;
    end else begin
      pix_valid   <= s1_valid;
      frame_start <= s1_first;
      income      <= s1_pix & rd_data[3'd7 - s1_bit];
      if (s1_valid) begin
        out_addr <= s1_cnt - LAG_A;
      end
    end
  end

endmodule

// File: tb/tb_img_stream_tx.sv
// Self-checking bench for img_stream_tx: random image, full-frame scoreboard,
// busy protection, mid-stream reset and same-cycle write/start.
module tb_img_stream_tx;
  import img_pkg::*;

  localparam int NBYTES = NPIX / 8;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               wr_en = 1'b0;
  logic [BYTE_AW-1:0] wr_addr = '0;
  logic [7:0]         wr_data = '0;
  logic               start = 1'b0;
  logic               busy, income, pix_valid, frame_start, done;
  logic [ADDR_W-1:0]  out_addr;

  logic [7:0] img [NBYTES];   // reference copy of the frame store
  int checks = 0;
  int errors = 0;

  img_stream_tx dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .busy        (busy),
    .income      (income),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .out_addr    (out_addr),
    .done        (done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // Expected serial pixel k of a frame: image bit MSB-first, zero in the flush tail.
  function automatic logic exp_income(input int k);
    logic [7:0] b;
    if (k >= NPIX) return 1'b0;
    b = img[k / 8];
    return b[7 - (k % 8)];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        0, 32'(busy),        0);
    check({tag, "_income"},      0, 32'(income),      0);
    check({tag, "_pix_valid"},   0, 32'(pix_valid),   0);
    check({tag, "_frame_start"}, 0, 32'(frame_start), 0);
    check({tag, "_out_addr"},    0, 32'(out_addr),    0);
    check({tag, "_done"},        0, 32'(done),        0);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check(tag, i, {30'd0, pix_valid, done}, 0);
    end
  endtask

  // Start a frame (optionally with a same-cycle host write) and score every output cycle.
  // abort_k >= 0 asserts reset after pixel abort_k; inject_k >= 0 tries a write+start mid-frame.
  task automatic run_frame(input logic do_wr, input logic [BYTE_AW-1:0] wa,
                           input logic [7:0] wd, input int abort_k, input int inject_k);
    int lat;
    logic [19:0] obs, exp;
    @(negedge clock);
    start   = 1'b1;
    wr_en   = do_wr;
    wr_addr = wa;
    wr_data = wd;
    if (do_wr) img[wa] = wd;
    @(negedge clock);
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_after_start", 0, 32'(busy), 1);
    lat = 0;
    while (pix_valid !== 1'b1 && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check("first_pixel_latency", 0, lat, 2);
    for (int k = 0; k < NPIX + LAG; k++) begin
      exp = {1'b1, 1'b0, 1'b1, (k == 0), exp_income(k), 15'(k - LAG)};
      obs = {busy, done, pix_valid, frame_start, income, out_addr};
      check("pixel", k, 32'(obs), 32'(exp));
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        return;
      end
      if (k == inject_k) begin
        wr_en   = 1'b1;
        wr_addr = 5;
        wr_data = 8'hFF;
        start   = 1'b1;
      end else if (k == inject_k + 1) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      @(negedge clock);
    end
    check("done_cycle", 0, {29'd0, busy, done, pix_valid}, 32'b010);
    @(negedge clock);
    check("after_done", 0, {29'd0, busy, done, pix_valid}, 0);
  endtask

  initial begin
    // Reset asserted mid-cycle clears outputs immediately.
    #3 reset = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle_cycles("idle_no_start", 100);

    // Load a random image, pixel 0 forced to a lone 1 in byte 0.
    for (int i = 0; i < NBYTES; i++) begin
      @(negedge clock);
      wr_en   = 1'b1;
      wr_addr = BYTE_AW'(i);
      wr_data = (i == 0) ? 8'h80 : 8'($urandom);
      img[i]  = wr_data;
    end
    @(negedge clock);
    wr_en = 1'b0;

    // Frame 1: write to byte 5 and a start pulse arrive while busy; both must be ignored.
    run_frame(1'b0, '0, '0, -1, 10);
    idle_cycles("idle_after_frame1", 5);

    // Frame 2: aborted by reset at pixel 1000; no done may follow.
    run_frame(1'b0, '0, '0, 1000, -1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle_cycles("idle_after_abort", 20);

    // Frame 3: restart with a byte-0 write in the same cycle as start; image otherwise intact.
    run_frame(1'b1, '0, 8'($urandom), -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
